// File: rtl/apb_req_bridge.sv
// Valid/ready request channel to APB master bridge; one transfer outstanding at a time.
// Define APB_REQ_BRIDGE_TIMEOUT_EN to bound the ACCESS-phase wait and add timeout_evt.
module apb_req_bridge #(
   parameter int unsigned PADDR_WIDTH    = 32,
   parameter int unsigned PWDATA_WIDTH   = 32,
   parameter int unsigned PRDATA_WIDTH   = 32,
   parameter int unsigned NUM_SLAVES     = 16,
   parameter int unsigned SLV_SEL_LSB    = 12,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic                    pclock21,
   input  logic                    preset21,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_write,
   input  logic [PADDR_WIDTH-1:0]  req_addr,
   input  logic [PWDATA_WIDTH-1:0] req_wdata,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [PRDATA_WIDTH-1:0] rsp_rdata,
   output logic                    rsp_err,
   output logic [PADDR_WIDTH-1:0]  paddr,
   output logic                    prwd,
   output logic [PWDATA_WIDTH-1:0] pwdata,
   output logic [15:0]             psel,
   output logic                    penable,
   input  logic                    pready,
   input  logic [PRDATA_WIDTH-1:0] prdata,
   input  logic                    pslverr
`ifdef APB_REQ_BRIDGE_TIMEOUT_EN
   ,
   output logic                    timeout_evt
`endif
);

   typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

   if (NUM_SLAVES < 1 || NUM_SLAVES > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_param
      $error("apb_req_bridge: NUM_SLAVES must be 1..16 and TIMEOUT_CYCLES at least 1");
   end

   state_e                  state_q, state_d;
   logic                    req_ready_q, req_ready_d;
   logic                    rsp_valid_q, rsp_valid_d;
   logic [PRDATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic                    rsp_err_q, rsp_err_d;
   logic [PADDR_WIDTH-1:0]  paddr_q, paddr_d;
   logic                    prwd_q, prwd_d;
   logic [PWDATA_WIDTH-1:0] pwdata_q, pwdata_d;
   logic [15:0]             psel_q, psel_d;
   logic                    penable_q, penable_d;

   logic [3:0]              req_idx;
   logic                    req_hit;

`ifdef APB_REQ_BRIDGE_TIMEOUT_EN
   localparam int unsigned CntW = ($clog2(TIMEOUT_CYCLES) < 8)  ? 8  :
                                  ($clog2(TIMEOUT_CYCLES) > 16) ? 16 : $clog2(TIMEOUT_CYCLES);
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            timeout_evt_q, timeout_evt_d;
`endif

   assign req_idx = req_addr[SLV_SEL_LSB +: 4];
   assign req_hit = ({28'd0, req_idx} < NUM_SLAVES);

   always_comb begin
      state_d     = state_q;
      req_ready_d = req_ready_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      paddr_d     = paddr_q;
      prwd_d      = prwd_q;
      pwdata_d    = pwdata_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
`ifdef APB_REQ_BRIDGE_TIMEOUT_EN
      cnt_d         = cnt_q;
      timeout_evt_d = 1'b0;
`endif
      case (state_q)
         StIdle: begin
            req_ready_d = 1'b1;
            // Accept uses the registered ready so the cycle after reset never accepts.
            if (req_valid && req_ready_q) begin
               req_ready_d = 1'b0;
               if (req_hit) begin
                  state_d   = StSetup;
                  paddr_d   = req_addr;
                  prwd_d    = req_write;
                  pwdata_d  = req_write ? req_wdata : '0;
                  psel_d    = 16'd1 << req_idx;
                  penable_d = 1'b0;
               end else begin
                  state_d     = StResp;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
                  rsp_rdata_d = '0;
               end
            end
         end
         StSetup: begin
            state_d   = StAccess;
            penable_d = 1'b1;
`ifdef APB_REQ_BRIDGE_TIMEOUT_EN
            cnt_d = '0;
`endif
         end
         StAccess: begin
            if (pready) begin
               state_d     = StResp;
               rsp_valid_d = 1'b1;
               rsp_err_d   = pslverr;
               rsp_rdata_d = (prwd_q || pslverr) ? '0 : prdata;
               psel_d      = '0;
               penable_d   = 1'b0;
`ifdef APB_REQ_BRIDGE_TIMEOUT_EN
            end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
               state_d       = StResp;
               rsp_valid_d   = 1'b1;
               rsp_err_d     = 1'b1;
               rsp_rdata_d   = '0;
               psel_d        = '0;
               penable_d     = 1'b0;
               timeout_evt_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
`endif
            end
         end
         StResp: begin
            if (rsp_ready) begin
               state_d     = StIdle;
               rsp_valid_d = 1'b0;
               req_ready_d = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge pclock21) begin
      if (!preset21) begin
         state_q     <= StIdle;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         paddr_q     <= '0;
         prwd_q      <= 1'b0;
         pwdata_q    <= '0;
         psel_q      <= '0;
         penable_q   <= 1'b0;
`ifdef APB_REQ_BRIDGE_TIMEOUT_EN
         cnt_q         <= '0;
         timeout_evt_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         paddr_q     <= paddr_d;
         prwd_q      <= prwd_d;
         pwdata_q    <= pwdata_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
`ifdef APB_REQ_BRIDGE_TIMEOUT_EN
         cnt_q         <= cnt_d;
         timeout_evt_q <= timeout_evt_d;
`endif
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign paddr     = paddr_q;
   assign prwd      = prwd_q;
   assign pwdata    = pwdata_q;
   assign psel      = psel_q;
   assign penable   = penable_q;
`ifdef APB_REQ_BRIDGE_TIMEOUT_EN
   assign timeout_evt = timeout_evt_q;
`endif

endmodule

// File: tb/tb_apb_req_bridge.sv
// Self-checking bench for apb_req_bridge: directed scenarios plus randomized transfers
// checked against a transaction-level model. Instance 1 has NUM_SLAVES = 8.
module tb_apb_req_bridge;

   localparam int unsigned TMO     = 4;
   localparam int unsigned SEL_LSB = 12;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        req_write;
   logic [31:0] req_addr, req_wdata;
   logic        pready, pslverr;
   logic [31:0] prdata;
   logic [1:0]  req_valid, rsp_ready;
   logic [1:0]  req_ready, rsp_valid, rsp_err, prwd, penable, tmo_evt;
   logic [31:0] rsp_rdata [2];
   logic [31:0] paddr     [2];
   logic [31:0] pwdata    [2];
   logic [15:0] psel      [2];

   int checks = 0;
   int errors = 0;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      apb_req_bridge #(
         .NUM_SLAVES     ((g == 0) ? 16 : 8),
         .SLV_SEL_LSB    (SEL_LSB),
         .TIMEOUT_CYCLES (TMO)
      ) u_dut (
`ifdef APB_REQ_BRIDGE_TIMEOUT_EN
         .timeout_evt (tmo_evt[g]),
`endif
         .pclock21  (clk),
         .preset21  (rst_n),
         .req_valid (req_valid[g]),
         .req_ready (req_ready[g]),
         .req_write (req_write),
         .req_addr  (req_addr),
         .req_wdata (req_wdata),
         .rsp_valid (rsp_valid[g]),
         .rsp_ready (rsp_ready[g]),
         .rsp_rdata (rsp_rdata[g]),
         .rsp_err   (rsp_err[g]),
         .paddr     (paddr[g]),
         .prwd      (prwd[g]),
         .pwdata    (pwdata[g]),
         .psel      (psel[g]),
         .penable   (penable[g]),
         .pready    (pready),
         .prdata    (prdata),
         .pslverr   (pslverr)
      );
   end

`ifndef APB_REQ_BRIDGE_TIMEOUT_EN
   assign tmo_evt = 2'b00;
`endif

   typedef struct {
      logic [15:0] psel;
      bit          psel_stable;
      int          psel_cyc;
      int          pen_cyc;
      logic [31:0] paddr;
      logic        prwd;
      logic [31:0] pwdata;
      int          lat;
      logic [31:0] rdata;
      logic        err;
      bit          rsp_stable;
      bit          rr_low;
      int          rsp_cyc;
      logic        rv_after;
      logic        rr_after;
      int          tmo;
      bit          hung;
      time         t_acc;
   } obs_t;

   typedef struct {
      bit          dec;
      bit          tmo;
      logic [15:0] psel;
      int          psel_cyc;
      int          pen_cyc;
      int          lat;
      logic [31:0] rdata;
      logic        err;
      logic [31:0] pwdata;
   } exp_t;

   // Transaction-level reference: what the APB bus and response look like for one request.
   function automatic exp_t model(input int u, input logic wr, input logic [31:0] addr,
                                  input logic [31:0] wdata, input int waits,
                                  input logic [31:0] rdat, input logic serr);
      exp_t e;
      int   ns    = (u == 0) ? 16 : 8;
      int   idx   = int'((addr >> SEL_LSB) & 32'hF);
      int   acc_n = waits + 1;
      e.tmo = 1'b0;
`ifdef APB_REQ_BRIDGE_TIMEOUT_EN
      if (waits >= TMO) begin
         e.tmo = 1'b1;
         acc_n = TMO;
      end
`endif
      e.dec = (idx >= ns);
      if (e.dec) begin
         e.psel = 16'h0; e.psel_cyc = 0; e.pen_cyc = 0; e.lat = 1;
         e.err = 1'b1; e.rdata = 32'h0; e.pwdata = 32'h0;
      end else begin
         e.psel     = 16'h1 << idx;
         e.psel_cyc = 1 + acc_n;
         e.pen_cyc  = acc_n;
         e.lat      = 2 + acc_n;
         e.err      = e.tmo | serr;
         e.rdata    = (e.tmo || wr || serr) ? 32'h0 : rdat;
         e.pwdata   = wr ? wdata : 32'h0;
      end
      return e;
   endfunction

   // Drives one request, plays a slave with `waits` wait states, holds rsp_ready low for
   // `hold` response cycles, and records what the bus did.
   task automatic run_xfer(input int u, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input int waits, input logic [31:0] rdat,
                           input logic serr, input int hold, input bit keep, output obs_t o);
      int cyc = 1, acc = 0, rc = 0, guard = 0;
      bit got_rsp = 0, handed = 0, done = 0;
      o = '{default: 0};
      o.psel_stable = 1; o.rsp_stable = 1; o.rr_low = 1;
      req_write = wr; req_addr = addr; req_wdata = wdata; req_valid[u] = 1'b1;
      while (req_ready[u] !== 1'b1 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 20) begin
         o.hung = 1; req_valid[u] = 1'b0;
         return;
      end
      @(negedge clk);
      o.t_acc = $time;
      if (!keep) req_valid[u] = 1'b0;
      while (!done && cyc < 400) begin
         if (handed) begin
            o.rv_after = rsp_valid[u];
            o.rr_after = req_ready[u];
            rsp_ready[u] = 1'b0;
            done = 1;
         end else begin
            if (psel[u] !== 16'h0) begin
               if (o.psel_cyc == 0) begin
                  o.psel = psel[u]; o.paddr = paddr[u]; o.prwd = prwd[u]; o.pwdata = pwdata[u];
               end else if (psel[u] !== o.psel || paddr[u] !== o.paddr || prwd[u] !== o.prwd ||
                            pwdata[u] !== o.pwdata) begin
                  o.psel_stable = 0;
               end
               o.psel_cyc++;
            end
            if (penable[u] === 1'b1) o.pen_cyc++;
            if (tmo_evt[u] === 1'b1) o.tmo++;
            if (req_ready[u] !== 1'b0) o.rr_low = 0;
            pready = 1'b0; pslverr = 1'b0; prdata = $urandom;
            if (psel[u] !== 16'h0 && penable[u] === 1'b1) begin
               if (acc == waits) begin
                  pready = 1'b1; prdata = rdat; pslverr = serr;
               end
               acc++;
            end
            if (rsp_valid[u] === 1'b1) begin
               if (!got_rsp) begin
                  got_rsp = 1; o.lat = cyc; o.rdata = rsp_rdata[u]; o.err = rsp_err[u];
               end else if (rsp_rdata[u] !== o.rdata || rsp_err[u] !== o.err) begin
                  o.rsp_stable = 0;
               end
               o.rsp_cyc++;
               rsp_ready[u] = (rc == hold);
               handed = (rc == hold);
               rc++;
            end
            @(negedge clk);
            cyc++;
         end
      end
      pready = 1'b0; pslverr = 1'b0;
      if (!done) o.hung = 1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int u = 0; u < 2; u++) begin
         checks++;
         if ({req_ready[u], rsp_valid[u], rsp_err[u], prwd[u], penable[u]} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctl[%0d]: got %b want 00000", u,
                     {req_ready[u], rsp_valid[u], rsp_err[u], prwd[u], penable[u]});
         end
         checks++;
         if ({psel[u], paddr[u], pwdata[u], rsp_rdata[u]} !== 112'h0) begin
            errors++;
            $display("FAIL reset_data[%0d]: psel=%h paddr=%h pwdata=%h rdata=%h want all 0",
                     u, psel[u], paddr[u], pwdata[u], rsp_rdata[u]);
         end
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready !== 2'b11) begin
         errors++;
         $display("FAIL reset_idle_ready: got %b want 11", req_ready);
      end
   endtask

   task automatic test_write_zero_wait();
      obs_t o;
      run_xfer(0, 1'b1, 32'h0000_2010, 32'hDEAD_BEEF, 0, 32'h0, 1'b0, 0, 0, o);
      checks++;
      if (o.hung || o.psel !== 16'h0004 || o.psel_cyc != 2 || o.pen_cyc != 1) begin
         errors++;
         $display("FAIL wr_psel: hung=%0d psel=%h cyc=%0d pen=%0d want 0004/2/1", o.hung,
                  o.psel, o.psel_cyc, o.pen_cyc);
      end
      checks++;
      if (o.prwd !== 1'b1 || o.pwdata !== 32'hDEAD_BEEF || o.paddr !== 32'h0000_2010) begin
         errors++;
         $display("FAIL wr_bus: prwd=%b pwdata=%h paddr=%h want 1/deadbeef/00002010", o.prwd,
                  o.pwdata, o.paddr);
      end
      checks++;
      if (o.lat != 3 || o.err !== 1'b0 || o.rdata !== 32'h0 || o.rr_after !== 1'b1) begin
         errors++;
         $display("FAIL wr_rsp: lat=%0d err=%b rdata=%h rr_after=%b want 3/0/0/1", o.lat,
                  o.err, o.rdata, o.rr_after);
      end
   endtask

   task automatic test_read_wait_states();
      obs_t o;
      run_xfer(0, 1'b0, 32'h0000_F004, 32'h5555_AAAA, 3, 32'h1234_5678, 1'b0, 0, 0, o);
      checks++;
      if (o.psel !== 16'h8000 || o.psel_cyc != 5 || o.pen_cyc != 4 || !o.psel_stable) begin
         errors++;
         $display("FAIL rd_wait_psel: psel=%h cyc=%0d pen=%0d stable=%0d want 8000/5/4/1",
                  o.psel, o.psel_cyc, o.pen_cyc, o.psel_stable);
      end
      checks++;
      if (o.prwd !== 1'b0 || o.pwdata !== 32'h0) begin
         errors++;
         $display("FAIL rd_wait_bus: prwd=%b pwdata=%h want 0/0", o.prwd, o.pwdata);
      end
      checks++;
      if (o.rdata !== 32'h1234_5678 || o.err !== 1'b0 || o.lat != 6) begin
         errors++;
         $display("FAIL rd_wait_rsp: rdata=%h err=%b lat=%0d want 12345678/0/6", o.rdata,
                  o.err, o.lat);
      end
   endtask

   task automatic test_slverr_backpressure();
      obs_t o;
      run_xfer(0, 1'b0, 32'h0000_3008, 32'h0, 1, 32'hCAFE_F00D, 1'b1, 5, 0, o);
      checks++;
      if (o.err !== 1'b1 || o.rdata !== 32'h0) begin
         errors++;
         $display("FAIL slverr_rsp: err=%b rdata=%h want 1/0", o.err, o.rdata);
      end
      checks++;
      if (o.rsp_cyc != 6 || !o.rsp_stable) begin
         errors++;
         $display("FAIL slverr_hold: valid_cycles=%0d stable=%0d want 6/1", o.rsp_cyc,
                  o.rsp_stable);
      end
      checks++;
      if (!o.rr_low || o.rr_after !== 1'b1 || o.rv_after !== 1'b0) begin
         errors++;
         $display("FAIL slverr_ready: rr_low=%0d rr_after=%b rv_after=%b want 1/1/0",
                  o.rr_low, o.rr_after, o.rv_after);
      end
   endtask

   task automatic test_decode_error();
      obs_t o;
      run_xfer(1, 1'b0, 32'h0000_9000, 32'h0, 0, 32'h7777_7777, 1'b0, 0, 0, o);
      checks++;
      if (o.hung || o.psel_cyc != 0 || o.pen_cyc != 0) begin
         errors++;
         $display("FAIL decode_bus: hung=%0d psel_cycles=%0d pen=%0d want 0/0/0", o.hung,
                  o.psel_cyc, o.pen_cyc);
      end
      checks++;
      if (o.lat != 1 || o.err !== 1'b1 || o.rdata !== 32'h0) begin
         errors++;
         $display("FAIL decode_rsp: lat=%0d err=%b rdata=%h want 1/1/0", o.lat, o.err,
                  o.rdata);
      end
   endtask

   task automatic test_reset_in_access();
      int guard = 0;
      bit rsp_seen = 0;
      req_write = 1'b0; req_addr = 32'h0000_5000; req_valid[0] = 1'b1;
      while (req_ready[0] !== 1'b1 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      @(negedge clk);
      req_valid[0] = 1'b0;
      pready = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (penable[0] !== 1'b1 || psel[0] !== 16'h0020) begin
         errors++;
         $display("FAIL rst_acc_pre: penable=%b psel=%h want 1/0020", penable[0], psel[0]);
      end
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if (psel[0] !== 16'h0 || penable[0] !== 1'b0 || rsp_valid[0] !== 1'b0 ||
          req_ready[0] !== 1'b0) begin
         errors++;
         $display("FAIL rst_acc_drop: psel=%h pen=%b rv=%b rr=%b want 0/0/0/0", psel[0],
                  penable[0], rsp_valid[0], req_ready[0]);
      end
      @(negedge clk);
      checks++;
      if (req_ready[0] !== 1'b0) begin
         errors++;
         $display("FAIL rst_acc_held: req_ready=%b want 0", req_ready[0]);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready[0] !== 1'b1) begin
         errors++;
         $display("FAIL rst_acc_release: req_ready=%b want 1", req_ready[0]);
      end
      rsp_ready[0] = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (rsp_valid[0] !== 1'b0 || psel[0] !== 16'h0) rsp_seen = 1;
      end
      rsp_ready[0] = 1'b0;
      checks++;
      if (rsp_seen) begin
         errors++;
         $display("FAIL rst_acc_no_rsp: stray response or bus activity after reset");
      end
   endtask

   task automatic test_back_to_back();
      obs_t o;
      time  t_prev = 0;
      for (int i = 0; i < 3; i++) begin
         run_xfer(0, 1'(i & 1), 32'h0000_1000 * (i + 1), $urandom, 0, $urandom, 1'b0, 0, 1, o);
         checks++;
         if (o.hung || o.lat != 3 || o.psel_cyc != 2 || o.rsp_cyc != 1 || !o.rr_low) begin
            errors++;
            $display("FAIL b2b[%0d]: hung=%0d lat=%0d psel_cyc=%0d rsp_cyc=%0d rr_low=%0d", i,
                     o.hung, o.lat, o.psel_cyc, o.rsp_cyc, o.rr_low);
         end
         if (i > 0) begin
            checks++;
            if (o.t_acc - t_prev != 40) begin
               errors++;
               $display("FAIL b2b_rate[%0d]: accept spacing %0t want 40", i, o.t_acc - t_prev);
            end
         end
         t_prev = o.t_acc;
      end
      req_valid[0] = 1'b0;
   endtask

`ifdef APB_REQ_BRIDGE_TIMEOUT_EN
   task automatic test_timeout();
      obs_t o;
      run_xfer(0, 1'b0, 32'h0000_4000, 32'h0, 1000, 32'hFFFF_FFFF, 1'b0, 0, 0, o);
      checks++;
      if (o.tmo != 1 || o.err !== 1'b1 || o.rdata !== 32'h0) begin
         errors++;
         $display("FAIL timeout_rsp: pulses=%0d err=%b rdata=%h want 1/1/0", o.tmo, o.err,
                  o.rdata);
      end
      checks++;
      if (o.pen_cyc != TMO || o.psel_cyc != TMO + 1 || o.lat != TMO + 2) begin
         errors++;
         $display("FAIL timeout_bus: pen=%0d psel=%0d lat=%0d want %0d/%0d/%0d", o.pen_cyc,
                  o.psel_cyc, o.lat, TMO, TMO + 1, TMO + 2);
      end
      run_xfer(0, 1'b0, 32'h0000_4000, 32'h0, TMO - 1, 32'hA5A5_0001, 1'b0, 0, 0, o);
      checks++;
      if (o.tmo != 0 || o.err !== 1'b0 || o.rdata !== 32'hA5A5_0001) begin
         errors++;
         $display("FAIL timeout_edge: pulses=%0d err=%b rdata=%h want 0/0/a5a50001", o.tmo,
                  o.err, o.rdata);
      end
   endtask
`endif

   task automatic test_random();
      obs_t o;
      exp_t e;
      for (int i = 0; i < 40; i++) begin
         int          u     = int'($urandom_range(0, 1));
         logic        wr    = 1'($urandom);
         logic [31:0] addr  = $urandom;
         logic [31:0] wdata = $urandom;
         logic [31:0] rdat  = $urandom;
         int          waits = int'($urandom_range(0, 5));
         int          hold  = int'($urandom_range(0, 3));
         logic        serr  = ($urandom_range(0, 3) == 0);
         e = model(u, wr, addr, wdata, waits, rdat, serr);
         run_xfer(u, wr, addr, wdata, waits, rdat, serr, hold, 0, o);
         checks++;
         if (o.hung || o.psel !== e.psel || o.psel_cyc != e.psel_cyc ||
             o.pen_cyc != e.pen_cyc || !o.psel_stable) begin
            errors++;
            $display("FAIL rnd[%0d] bus: hung=%0d psel=%h/%h cyc=%0d/%0d pen=%0d/%0d st=%0d",
                     i, o.hung, o.psel, e.psel, o.psel_cyc, e.psel_cyc, o.pen_cyc, e.pen_cyc,
                     o.psel_stable);
         end
         if (!e.dec) begin
            checks++;
            if (o.paddr !== addr || o.prwd !== wr || o.pwdata !== e.pwdata) begin
               errors++;
               $display("FAIL rnd[%0d] addr: paddr=%h/%h prwd=%b/%b pwdata=%h/%h", i,
                        o.paddr, addr, o.prwd, wr, o.pwdata, e.pwdata);
            end
         end
         checks++;
         if (o.lat != e.lat || o.rdata !== e.rdata || o.err !== e.err) begin
            errors++;
            $display("FAIL rnd[%0d] rsp: lat=%0d/%0d rdata=%h/%h err=%b/%b", i, o.lat,
                     e.lat, o.rdata, e.rdata, o.err, e.err);
         end
         checks++;
         if (o.rsp_cyc != hold + 1 || !o.rsp_stable || !o.rr_low || o.rr_after !== 1'b1) begin
            errors++;
            $display("FAIL rnd[%0d] hs: vcyc=%0d/%0d stable=%0d rr_low=%0d rr_after=%b", i,
                     o.rsp_cyc, hold + 1, o.rsp_stable, o.rr_low, o.rr_after);
         end
`ifdef APB_REQ_BRIDGE_TIMEOUT_EN
         checks++;
         if (o.tmo != int'(e.tmo)) begin
            errors++;
            $display("FAIL rnd[%0d] tmo: pulses=%0d want %0d", i, o.tmo, e.tmo);
         end
`endif
      end
   endtask

   initial begin
      #200us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;
      req_write = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
      pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;
      test_reset();
      test_write_zero_wait();
      test_read_wait_states();
      test_slverr_backpressure();
      test_decode_error();
      test_reset_in_access();
      test_back_to_back();
`ifdef APB_REQ_BRIDGE_TIMEOUT_EN
      test_timeout();
`endif
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
